// File: rtl/bcd_down_counter.sv
// Multi-digit BCD countdown timer with load, run/pause and terminal-count pulse.
// Latency: Q/busy/done update on the clk edge that samples load/start/tick; zero is combinational from Q.
// No backpressure: one decrement per accepted tick; ticks outside RUN are dropped.
module bcd_down_counter #(
    parameter int NDIGITS = 2,
    parameter int RELOAD  = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic [4*NDIGITS-1:0]   load_val,
    input  logic                   start,
    input  logic                   tick,
    output logic [4*NDIGITS-1:0]   Q,
    output logic                   zero,
    output logic                   busy,
    output logic                   done
);

    localparam int W = 4 * NDIGITS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   count_q, count_d;
    logic [W-1:0]   rld_q, rld_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [W-1:0]   clamped;
    logic [W-1:0]   decremented;
    logic           count_is_zero;
    logic           count_is_one;

    always_comb begin
        clamped = '0;
        for (int i = 0; i < NDIGITS; i++) begin
            clamped[4*i +: 4] = (load_val[4*i +: 4] > 4'd9) ? 4'd9 : load_val[4*i +: 4];
        end
    end

    // Ripple borrow: a digit moves only while every lower digit was 0 (and wrapped to 9).
    always_comb begin : dec_blk
        logic borrow;
        borrow      = 1'b1;
        decremented = count_q;
        for (int i = 0; i < NDIGITS; i++) begin
            if (borrow) begin
                if (count_q[4*i +: 4] == 4'd0) begin
                    decremented[4*i +: 4] = 4'd9;
                end else begin
                    decremented[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
                    borrow                = 1'b0;
                end
            end
        end
    end

    assign count_is_zero = (count_q == '0);
    assign count_is_one  = (count_q == W'(1));

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        rld_d   = rld_q;
        done_d  = 1'b0;
        if (load) begin
            count_d = clamped;
            rld_d   = clamped;
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && !count_is_zero) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (!start) begin
                        state_d = PAUSE;
                    end else if (tick) begin
                        if (count_is_zero) begin
                            // Periodic mode parks at 0 for one tick, then restarts from the reload value.
                            count_d = rld_q;
                        end else begin
                            count_d = decremented;
                            if (count_is_one) begin
                                done_d  = 1'b1;
                                state_d = ((RELOAD != 0) && (rld_q != '0)) ? RUN : IDLE;
                            end
                        end
                    end
                end
                PAUSE: begin
                    if (start) begin
                        state_d = RUN;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        busy_d = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            count_q <= '0;
            rld_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            rld_q   <= rld_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign Q    = count_q;
    assign zero = count_is_zero;
    assign busy = busy_q;
    assign done = done_q;

endmodule
